yuv422_to_yuv444_stream: RTL and testbench
==========================================

Name: yuv422_to_yuv444_stream

Overview:
Parametrised, valid-qualified successor to the free-running 4:2:2→4:4:4 unpacker. Accepts a 4:2:2 beat stream of {Y, C} words with data-valid and start-of-line strobes, pairs each even and odd beat, and emits one full 4:4:4 pixel per accepted beat. Every output pixel of a pair carries both chroma samples of that pair. Handles gapped input, line-start realignment and orphaned even beats. Sits between the capture/decoder front end and the colour-space/segmentation stages of the tracking pipeline.

Parameters:
DATA_W, 8, bits per component (Y, Cb, Cr); legal 8..12
CB_FIRST, 1, 1: even beat carries Cb and odd beat carries Cr; 0: order swapped
ORPHAN_FLUSH, 1, 1: emit an orphaned even pixel on realignment; 0: drop it

Ports:
iCLK  in  1  clock
iRST_N  in  1  synchronous active-low reset
iYCbCr  in  2*DATA_W  beat word; [2*DATA_W-1:DATA_W]=Y, [DATA_W-1:0]=chroma
iDVAL  in  1  beat valid; beat accepted on any iCLK edge with iDVAL=1
iSOL  in  1  first beat of a line; qualified by iDVAL
oY  out  DATA_W  luma
oCb  out  DATA_W  blue chroma
oCr  out  DATA_W  red chroma
oDVAL  out  1  output pixel valid, exactly one cycle per pixel
oSOL  out  1  marks first output pixel of a line, concurrent with oDVAL
oORPHAN  out  1  one-cycle pulse, orphan detected

Behaviour:
- Reset is synchronous on iCLK with iRST_N=0. All outputs go to 0, phase goes to EVEN, all held samples go to 0, pending flags clear. Reset mid-line discards any partial pair with no flush.
- Phase FSM has two states, EVEN and ODD. An accepted beat in EVEN stores Y0, C0 and the line-start flag, then moves to ODD. An accepted beat in ODD stores Y1, C1 and moves to EVEN. Cycles with iDVAL=0 do not change state.
- Chroma mapping uses CB_FIRST=1: Cb=C0, Cr=C1. With CB_FIRST=0: Cb=C1, Cr=C0.
- Output timing for an odd beat accepted at edge t:
  - edge t+1: oDVAL=1, {Y0, Cb, Cr}, oSOL=stored line-start flag.
  - edge t+2: oDVAL=1, {Y1, Cb, Cr}, oSOL=0.
  - Fixed latency is 2 cycles from the odd beat to the odd pixel.
  - The edge t+2 emission happens regardless of iDVAL at t+1.
- Back-to-back input sustains one pixel per cycle; the output never stalls and there is no backpressure. Outside emission cycles oDVAL=0, and oY/oCb/oCr hold their last values.
- An accepted beat with iSOL=1 while in EVEN is a normal line start.
- Orphan case: an accepted beat with iSOL=1 while in ODD (previous line ended on an even beat).
  - oORPHAN pulses at the next edge.
  - With ORPHAN_FLUSH=1, the pending even pixel is emitted at the next edge as {Y0, C0 per mapping, missing chroma=2^(DATA_W-1)}, with oSOL=its stored flag.
  - With ORPHAN_FLUSH=0, nothing is emitted.
  - In both cases the new beat is treated as EVEN: it is stored, its line-start flag is set, and the FSM moves to ODD.
  - No collision with the odd-pixel slot is possible, because that slot is always consumed before the next ODD-phase beat.
- An accepted beat with iSOL=1 while in EVEN with no pending pair has no side effects.
- No arithmetic is performed on data paths (pure routing), except the optional clamp.

Optional Feature:
Macro YUV444_RANGE_CLAMP_EN.
- Defined: output components are clamped to nominal video range before the output register. Y is clamped to [16<<(DATA_W-8), 235<<(DATA_W-8)]; Cb and Cr to [16<<(DATA_W-8), 240<<(DATA_W-8)]. Latency is unchanged.
- Not defined: full-range pass-through with no clamp logic.

Test Plan:
- DATA_W=8, CB_FIRST=1, reset, then continuous beats 0x5010, 0x60F0 (iSOL=1 on the first) → edge t+1: Y=0x50, Cb=0x10, Cr=0xF0, oSOL=1; edge t+2: Y=0x60, Cb=0x10, Cr=0xF0, oSOL=0.
- 8 continuous beats with iDVAL=1 → oDVAL high for exactly 8 consecutive cycles starting 1 cycle after the 2nd beat; pixel pairs carry matching chroma.
- Same pair with 3 idle cycles between beats → outputs identical to the gapless case, relative to the odd beat.
- Even beat 0x7020, then iSOL beat 0x8030 → oORPHAN=1 one cycle; with ORPHAN_FLUSH=1, pixel Y=0x70, Cb=0x20, Cr=0x80; with ORPHAN_FLUSH=0, no oDVAL. The following odd beat 0x9040 yields Y=0x80, Cb=0x30, Cr=0x40, oSOL=1.
- Assert iRST_N=0 for 1 cycle after an even beat → no flush, outputs 0, next odd-looking beat is treated as EVEN.
- With YUV444_RANGE_CLAMP_EN, beats 0x0000, 0xFFFF → pixels Y=16, Cb=16, Cr=240, then Y=235, Cb=16, Cr=240.

Source files
------------

// File: rtl/yuv422_to_yuv444_stream.sv
// 4:2:2 {Y,C} beat stream to 4:4:4 pixel stream with line-start realignment and orphan handling.
// Optional build macro YUV444_RANGE_CLAMP_EN clamps outputs to nominal video range.
module yuv422_to_yuv444_stream #(
    parameter int DATA_W       = 8,
    parameter int CB_FIRST     = 1,
    parameter int ORPHAN_FLUSH = 1
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic [2*DATA_W-1:0]   iYCbCr,
    input  logic                  iDVAL,
    input  logic                  iSOL,
    output logic [DATA_W-1:0]     oY,
    output logic [DATA_W-1:0]     oCb,
    output logic [DATA_W-1:0]     oCr,
    output logic                  oDVAL,
    output logic                  oSOL,
    output logic                  oORPHAN
);

    localparam logic [DATA_W-1:0] CHROMA_MID = {1'b1, {(DATA_W-1){1'b0}}};

`ifdef YUV444_RANGE_CLAMP_EN
    localparam logic [DATA_W-1:0] RANGE_LO = DATA_W'(16 << (DATA_W-8));
    localparam logic [DATA_W-1:0] Y_HI     = DATA_W'(235 << (DATA_W-8));
    localparam logic [DATA_W-1:0] C_HI     = DATA_W'(240 << (DATA_W-8));

    function automatic logic [DATA_W-1:0] clampRange(input logic [DATA_W-1:0] v,
                                                     input logic [DATA_W-1:0] lo,
                                                     input logic [DATA_W-1:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction
`endif

    function automatic logic [DATA_W-1:0] lumaOut(input logic [DATA_W-1:0] v);
`ifdef YUV444_RANGE_CLAMP_EN
        return clampRange(v, RANGE_LO, Y_HI);
`else
        return v;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] chromaOut(input logic [DATA_W-1:0] v);
`ifdef YUV444_RANGE_CLAMP_EN
        return clampRange(v, RANGE_LO, C_HI);
`else
        return v;
`endif
    endfunction

    typedef enum logic {EVEN = 1'b0, ODD = 1'b1} phase_t;

    phase_t phase, phaseNext;
    logic   acceptEven, acceptOdd, orphanEvt;

    logic [DATA_W-1:0] beatY, beatC;
    assign beatY = iYCbCr[2*DATA_W-1:DATA_W];
    assign beatC = iYCbCr[DATA_W-1:0];

    logic [DATA_W-1:0] evenY_p0, evenC_p0;
    logic              evenSol_p0;

    logic [DATA_W-1:0] pairY0_p1, pairY1_p1, pairCb_p1, pairCr_p1;
    logic              pairSol_p1, vldPair_p1, vldFlush_p1, orphan_p1;
    logic              vldSecond_p2;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) phase <= EVEN;
        else         phase <= phaseNext;
    end

    // A line-start beat seen in ODD abandons the pending even beat and restarts the pair.
    always_comb begin
        phaseNext  = phase;
        acceptEven = 1'b0;
        acceptOdd  = 1'b0;
        orphanEvt  = 1'b0;
        if (iDVAL) begin
            case (phase)
                EVEN: begin
                    acceptEven = 1'b1;
                    phaseNext  = ODD;
                end
                ODD: begin
                    if (iSOL) begin
                        orphanEvt  = 1'b1;
                        acceptEven = 1'b1;
                        phaseNext  = ODD;
                    end else begin
                        acceptOdd = 1'b1;
                        phaseNext = EVEN;
                    end
                end
                default: phaseNext = EVEN;
            endcase
        end
    end

    // Stage p0: hold the even beat of the pair being assembled
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            evenY_p0   <= '0;
            evenC_p0   <= '0;
            evenSol_p0 <= 1'b0;
        end else if (acceptEven) begin
            evenY_p0   <= beatY;
            evenC_p0   <= beatC;
            evenSol_p0 <= iSOL;
        end
    end

    // Stage p1: completed pair (or orphan flush pixel) ready for emission
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            pairY0_p1   <= '0;
            pairY1_p1   <= '0;
            pairCb_p1   <= '0;
            pairCr_p1   <= '0;
            pairSol_p1  <= 1'b0;
            vldPair_p1  <= 1'b0;
            vldFlush_p1 <= 1'b0;
            orphan_p1   <= 1'b0;
        end else begin
            vldPair_p1  <= acceptOdd;
            vldFlush_p1 <= orphanEvt && (ORPHAN_FLUSH != 0);
            orphan_p1   <= orphanEvt;
            if (acceptOdd) begin
                pairY0_p1  <= evenY_p0;
                pairY1_p1  <= beatY;
                pairCb_p1  <= (CB_FIRST != 0) ? evenC_p0 : beatC;
                pairCr_p1  <= (CB_FIRST != 0) ? beatC : evenC_p0;
                pairSol_p1 <= evenSol_p0;
            end else if (orphanEvt && (ORPHAN_FLUSH != 0)) begin
                pairY0_p1  <= evenY_p0;
                pairCb_p1  <= (CB_FIRST != 0) ? evenC_p0 : CHROMA_MID;
                pairCr_p1  <= (CB_FIRST != 0) ? CHROMA_MID : evenC_p0;
                pairSol_p1 <= evenSol_p0;
            end
        end
    end

    // Stage p2: odd pixel slot, always one cycle behind the even pixel
    always_ff @(posedge iCLK) begin
        if (!iRST_N) vldSecond_p2 <= 1'b0;
        else         vldSecond_p2 <= vldPair_p1;
    end

    // Output register: the three emission sources never coincide
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            oY      <= '0;
            oCb     <= '0;
            oCr     <= '0;
            oDVAL   <= 1'b0;
            oSOL    <= 1'b0;
            oORPHAN <= 1'b0;
        end else begin
            oORPHAN <= orphan_p1;
            if (vldPair_p1 || vldFlush_p1) begin
                oY    <= lumaOut(pairY0_p1);
                oCb   <= chromaOut(pairCb_p1);
                oCr   <= chromaOut(pairCr_p1);
                oDVAL <= 1'b1;
                oSOL  <= pairSol_p1;
            end else if (vldSecond_p2) begin
                oY    <= lumaOut(pairY1_p1);
                oCb   <= chromaOut(pairCb_p1);
                oCr   <= chromaOut(pairCr_p1);
                oDVAL <= 1'b1;
                oSOL  <= 1'b0;
            end else begin
                oDVAL <= 1'b0;
                oSOL  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_yuv422_to_yuv444_stream.sv
// Bench for yuv422_to_yuv444_stream: two instances (CB_FIRST/ORPHAN_FLUSH = 1/1 and 0/0) against a cycle-scheduled model.
module tb_yuv422_to_yuv444_stream;
    localparam int W = 8;
    localparam int N = 4096;
    localparam logic [W-1:0] MID = 8'h80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           iRST_N, iDVAL, iSOL;
    logic [2*W-1:0] iYCbCr;

    logic [W-1:0] y0, cb0, cr0, y1, cb1, cr1;
    logic         v0, s0, o0, v1, s1, o1;

    yuv422_to_yuv444_stream #(.DATA_W(W), .CB_FIRST(1), .ORPHAN_FLUSH(1)) dutA (
        .iCLK(clk), .iRST_N(iRST_N), .iYCbCr(iYCbCr), .iDVAL(iDVAL), .iSOL(iSOL),
        .oY(y0), .oCb(cb0), .oCr(cr0), .oDVAL(v0), .oSOL(s0), .oORPHAN(o0));

    yuv422_to_yuv444_stream #(.DATA_W(W), .CB_FIRST(0), .ORPHAN_FLUSH(0)) dutB (
        .iCLK(clk), .iRST_N(iRST_N), .iYCbCr(iYCbCr), .iDVAL(iDVAL), .iSOL(iSOL),
        .oY(y1), .oCb(cb1), .oCr(cr1), .oDVAL(v1), .oSOL(s1), .oORPHAN(o1));

    int checks = 0;
    int errors = 0;
    int e = 0;

    // Expected events per clock edge, per instance
    logic         expV [2][N];
    logic         expS [2][N];
    logic         expO [2][N];
    logic [W-1:0] expY [2][N];
    logic [W-1:0] expCb[2][N];
    logic [W-1:0] expCr[2][N];
    logic         expRst[N];

    logic [W-1:0] holdY[2], holdCb[2], holdCr[2];

    // Model state: phase and the pending even beat
    logic         mOdd;
    logic [W-1:0] mY0, mC0;
    logic         mS0;

    function automatic logic [W-1:0] fixY(input logic [W-1:0] v);
`ifdef YUV444_RANGE_CLAMP_EN
        return (v < 16) ? 8'd16 : ((v > 235) ? 8'd235 : v);
`else
        return v;
`endif
    endfunction

    function automatic logic [W-1:0] fixC(input logic [W-1:0] v);
`ifdef YUV444_RANGE_CLAMP_EN
        return (v < 16) ? 8'd16 : ((v > 240) ? 8'd240 : v);
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", name, e, act, req);
        end
    endtask

    task automatic setPix(input int k, input int at, input logic [W-1:0] y,
                          input logic [W-1:0] cb, input logic [W-1:0] cr, input logic sol);
        expV[k][at]  = 1'b1;
        expY[k][at]  = fixY(y);
        expCb[k][at] = fixC(cb);
        expCr[k][at] = fixC(cr);
        expS[k][at]  = sol;
    endtask

    task automatic modelEdge();
        logic [W-1:0] by, bc, cb, cr;
        bit cbFirst, flush;
        by = iYCbCr[2*W-1:W];
        bc = iYCbCr[W-1:0];
        if (!iRST_N) begin
            mOdd = 1'b0; mY0 = '0; mC0 = '0; mS0 = 1'b0;
            expRst[e] = 1'b1;
            for (int k = 0; k < 2; k++)
                for (int j = 0; j < 3; j++) begin
                    expV[k][e+j] = 1'b0;
                    expO[k][e+j] = 1'b0;
                end
        end else if (iDVAL) begin
            if (mOdd && iSOL) begin
                for (int k = 0; k < 2; k++) begin
                    cbFirst = (k == 0);
                    flush   = (k == 0);
                    expO[k][e+1] = 1'b1;
                    if (flush)
                        setPix(k, e+1, mY0, cbFirst ? mC0 : MID, cbFirst ? MID : mC0, mS0);
                end
                mY0 = by; mC0 = bc; mS0 = 1'b1;
            end else if (!mOdd) begin
                mY0 = by; mC0 = bc; mS0 = iSOL; mOdd = 1'b1;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    cbFirst = (k == 0);
                    cb = cbFirst ? mC0 : bc;
                    cr = cbFirst ? bc : mC0;
                    setPix(k, e+1, mY0, cb, cr, mS0);
                    setPix(k, e+2, by, cb, cr, 1'b0);
                end
                mOdd = 1'b0;
            end
        end
    endtask

    task automatic compareAll();
        logic [W-1:0] ay, acb, acr;
        logic av, as, ao;
        for (int k = 0; k < 2; k++) begin
            if (expRst[e]) begin
                holdY[k] = '0; holdCb[k] = '0; holdCr[k] = '0;
            end else if (expV[k][e]) begin
                holdY[k] = expY[k][e]; holdCb[k] = expCb[k][e]; holdCr[k] = expCr[k][e];
            end
            ay  = (k == 0) ? y0  : y1;
            acb = (k == 0) ? cb0 : cb1;
            acr = (k == 0) ? cr0 : cr1;
            av  = (k == 0) ? v0  : v1;
            as  = (k == 0) ? s0  : s1;
            ao  = (k == 0) ? o0  : o1;
            chk($sformatf("oDVAL[%0d]", k), av, expV[k][e]);
            chk($sformatf("oSOL[%0d]", k), as, expV[k][e] & expS[k][e]);
            chk($sformatf("oORPHAN[%0d]", k), ao, expO[k][e]);
            chk($sformatf("oY[%0d]", k), ay, holdY[k]);
            chk($sformatf("oCb[%0d]", k), acb, holdCb[k]);
            chk($sformatf("oCr[%0d]", k), acr, holdCr[k]);
        end
    endtask

    task automatic step(input logic r, input logic d, input logic s, input logic [2*W-1:0] w);
        iRST_N = r; iDVAL = d; iSOL = s; iYCbCr = w;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        compareAll();
        e++;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) begin
                expV[k][i] = 1'b0; expS[k][i] = 1'b0; expO[k][i] = 1'b0;
                expY[k][i] = '0; expCb[k][i] = '0; expCr[k][i] = '0;
            end
        for (int i = 0; i < N; i++) expRst[i] = 1'b0;
        mOdd = 1'b0; mY0 = '0; mC0 = '0; mS0 = 1'b0;
        iRST_N = 1'b0; iDVAL = 1'b0; iSOL = 1'b0; iYCbCr = '0;

        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 16'h1234);
        chk("rst_oY", y0, 0);
        chk("rst_oDVAL", v0, 0);

        // Basic pair, gapless
        step(1'b1, 1'b1, 1'b1, 16'h5010);
        step(1'b1, 1'b1, 1'b0, 16'h60F0);
        idle();
        chk("p0_Y", y0, 8'h50); chk("p0_Cb", cb0, 8'h10); chk("p0_Cr", cr0, 8'hF0);
        chk("p0_SOL", s0, 1); chk("p0_DVAL", v0, 1);
        chk("p0_CbSwap", cb1, 8'hF0); chk("p0_CrSwap", cr1, 8'h10);
        idle();
        chk("p1_Y", y0, 8'h60); chk("p1_Cb", cb0, 8'h10); chk("p1_SOL", s0, 0); chk("p1_DVAL", v0, 1);
        idle();
        chk("hold_DVAL", v0, 0); chk("hold_Y", y0, 8'h60);

        // Same pair with three idle cycles between beats
        step(1'b1, 1'b1, 1'b1, 16'h5010);
        idle(); idle(); idle();
        step(1'b1, 1'b1, 1'b0, 16'h60F0);
        idle();
        chk("gap_p0_Y", y0, 8'h50); chk("gap_p0_SOL", s0, 1);
        idle();
        chk("gap_p1_Y", y0, 8'h60); chk("gap_p1_Cr", cr0, 8'hF0);

        // Eight back-to-back beats
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, (i == 0), 16'(16'h2100 + i * 16'h1011));
        idle(); idle(); idle();

        // Orphaned even beat followed by a new line
        step(1'b1, 1'b1, 1'b0, 16'h7020);
        step(1'b1, 1'b1, 1'b1, 16'h8030);
        idle();
        chk("orph_pulseA", o0, 1); chk("orph_pulseB", o1, 1);
        chk("orph_flushV", v0, 1); chk("orph_flushY", y0, 8'h70);
        chk("orph_flushCb", cb0, 8'h20); chk("orph_flushCr", cr0, 8'h80);
        chk("orph_noflushV", v1, 0);
        step(1'b1, 1'b1, 1'b0, 16'h9040);
        idle();
        chk("orph_nextY", y0, 8'h80); chk("orph_nextCb", cb0, 8'h30);
        chk("orph_nextCr", cr0, 8'h40); chk("orph_nextSOL", s0, 1);
        chk("orph_nextCbSwap", cb1, 8'h40); chk("orph_nextSOLB", s1, 1);
        idle(); idle();

        // Reset after an even beat discards it
        step(1'b1, 1'b1, 1'b1, 16'hA050);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("rstmid_Y", y0, 0); chk("rstmid_Cb", cb0, 0);
        step(1'b1, 1'b1, 1'b0, 16'hB060);
        step(1'b1, 1'b1, 1'b0, 16'hC070);
        idle();
        chk("rstmid_pY", y0, 8'hB0); chk("rstmid_pCb", cb0, 8'h60);
        chk("rstmid_pCr", cr0, 8'h70); chk("rstmid_pSOL", s0, 0);
        idle(); idle();

`ifdef YUV444_RANGE_CLAMP_EN
        step(1'b1, 1'b1, 1'b1, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 16'hFFFF);
        idle();
        chk("clamp_Y0", y0, 16); chk("clamp_Cb", cb0, 16); chk("clamp_Cr", cr0, 240);
        idle();
        chk("clamp_Y1", y0, 235);
        idle();
`endif

        // Randomized traffic with gaps, line starts and rare resets
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0), 16'($urandom));
        idle(); idle(); idle(); idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
